// File: rtl/pe_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_tile_sequencer_if
//  Description : Command and beat bundle between the execute-command queue,
//                the tile sequencer and the PE mesh input skew registers.
//                master : command producer / beat consumer side
//                slave  : the sequencer itself
//  Signals     : cmd_valid/cmd_ready handshake with cmd_dataflow, cmd_preload,
//                cmd_shift, cmd_rows; out_valid/out_ready beat handshake with
//                out_control_dataflow, out_control_propagate,
//                out_control_shift, out_id, out_last; done/done_id completion
//                pulse; bad_dataflow sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_tile_sequencer_if #(
    parameter int ROWS_W  = 5,
    parameter int ID_W    = 3,
    parameter int SHIFT_W = 5
);
    // Tile command
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dataflow;
    logic               cmd_preload;
    logic [SHIFT_W-1:0] cmd_shift;
    logic [ROWS_W-1:0]  cmd_rows;

    // Per-row beat towards the mesh
    logic               out_valid;
    logic               out_ready;
    logic               out_control_dataflow;
    logic               out_control_propagate;
    logic [SHIFT_W-1:0] out_control_shift;
    logic [ID_W-1:0]    out_id;
    logic               out_last;

    // Completion and status
    logic               done;
    logic [ID_W-1:0]    done_id;
    logic               bad_dataflow;

    modport master (
        output cmd_valid, cmd_dataflow, cmd_preload, cmd_shift, cmd_rows,
        output out_ready,
        input  cmd_ready,
        input  out_valid, out_control_dataflow, out_control_propagate,
        input  out_control_shift, out_id, out_last,
        input  done, done_id, bad_dataflow
    );

    modport slave (
        input  cmd_valid, cmd_dataflow, cmd_preload, cmd_shift, cmd_rows,
        input  out_ready,
        output cmd_ready,
        output out_valid, out_control_dataflow, out_control_propagate,
        output out_control_shift, out_id, out_last,
        output done, done_id, bad_dataflow
    );
endinterface : pe_tile_sequencer_if
`default_nettype wire

// File: rtl/pe_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pe_tile_sequencer
//  Description : Turns one tile command into the per-row control beats for
//                the PE mesh: an optional PRELOAD phase, a COMPUTE phase,
//                then FLUSH bubbles so the mesh drains before a one-cycle
//                done pulse reports the tile id.
//  Ports       : clock  - single clock
//                reset  - synchronous, active-high
//                bus    - pe_tile_sequencer_if.slave (command handshake,
//                         beat handshake, done/done_id, bad_dataflow)
//  Options     : HF_PE_SEQ_BAD_DATAFLOW_EN - when defined, a command whose
//                dataflow is not allowed by DF_SUPPORT raises the sticky
//                bad_dataflow flag and is consumed as an empty tile. When
//                undefined, bad_dataflow is tied low and every dataflow value
//                is passed through.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_tile_sequencer #(
    parameter int MAX_ROWS     = 16,
    parameter int ROWS_W       = 5,
    parameter int ID_W         = 3,
    parameter int SHIFT_W      = 5,
    parameter int FLUSH_CYCLES = 4,
    parameter int DF_SUPPORT   = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    pe_tile_sequencer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if ((DF_SUPPORT < 0) || (DF_SUPPORT > 2)) begin : g_bad_df_support
        $error("pe_tile_sequencer: DF_SUPPORT must be 0, 1 or 2");
    end

    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
        $error("pe_tile_sequencer: FLUSH_CYCLES must be at least 1");
    end

    if (MAX_ROWS >= (1 << ROWS_W)) begin : g_bad_rows_w
        $error("pe_tile_sequencer: MAX_ROWS does not fit in ROWS_W bits");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [ROWS_W-1:0]  C_MAX_ROWS   = ROWS_W'(MAX_ROWS);
    localparam logic [FLUSH_W-1:0] C_FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRELOAD = 2'd1,
        S_COMPUTE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic [ROWS_W-1:0]    r_rows;        // beats per phase for the active tile
    logic [ROWS_W-1:0]    r_beat_cnt;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic [ID_W-1:0]      r_id;
    logic                 r_prop;
    logic                 r_dataflow;
    logic [SHIFT_W-1:0]   r_shift;
    logic                 r_done;
    logic [ID_W-1:0]      r_done_id;

    logic                 w_cmd_ready;
    logic                 w_accept;
    logic [ROWS_W-1:0]    w_rows_eff;
    logic                 w_df_bad;
    logic                 w_tile_empty;
    logic                 w_out_valid;
    logic                 w_beat_fire;
    logic                 w_beat_last;
    logic                 w_flush_last;
    logic                 w_out_last;

    // ------------------------------------------------------------------------
    // Command acceptance
    // ------------------------------------------------------------------------
    // Ready is gated by reset so nothing is taken in the reset cycle even
    // though the state register may still show IDLE.
    assign w_cmd_ready = (r_state == S_IDLE) && !reset;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;

    // Oversized row counts are clamped rather than rejected.
    assign w_rows_eff  = (bus.cmd_rows > C_MAX_ROWS) ? C_MAX_ROWS : bus.cmd_rows;

`ifdef HF_PE_SEQ_BAD_DATAFLOW_EN
    // DF_SUPPORT: 0 = OS only (dataflow 0), 1 = WS only (dataflow 1), 2 = both.
    assign w_df_bad = ((DF_SUPPORT == 0) &&  bus.cmd_dataflow) ||
                      ((DF_SUPPORT == 1) && !bus.cmd_dataflow);
`else
    assign w_df_bad = 1'b0;
`endif

    // An empty tile produces no beats, keeps id/propagate and goes straight
    // to FLUSH so it still yields a done pulse.
    assign w_tile_empty = (w_rows_eff == '0) || w_df_bad;

    // ------------------------------------------------------------------------
    // Beat and flush bookkeeping
    // ------------------------------------------------------------------------
    assign w_out_valid  = (r_state == S_PRELOAD) || (r_state == S_COMPUTE);
    assign w_beat_fire  = w_out_valid && bus.out_ready;
    assign w_beat_last  = (r_beat_cnt == (r_rows - 1'b1));
    assign w_flush_last = (r_flush_cnt == C_FLUSH_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_out_last   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_tile_empty) begin
                        w_state_next = S_FLUSH;
                    end else if (bus.cmd_preload) begin
                        w_state_next = S_PRELOAD;
                    end else begin
                        w_state_next = S_COMPUTE;
                    end
                end
            end

            S_PRELOAD: begin
                if (w_beat_fire && w_beat_last) begin
                    w_state_next = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
                // last is a pure function of the held counter, so it stays
                // stable while the mesh back-pressures.
                w_out_last = w_beat_last;
                if (w_beat_fire && w_beat_last) begin
                    w_state_next = S_FLUSH;
                end
            end

            S_FLUSH: begin
                if (w_flush_last) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rows      <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_id        <= '0;
            r_prop      <= 1'b0;
            r_dataflow  <= 1'b0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_dataflow  <= bus.cmd_dataflow;
                r_shift     <= bus.cmd_shift;
                r_beat_cnt  <= '0;
                r_flush_cnt <= '0;
                r_rows      <= w_tile_empty ? '0 : w_rows_eff;
                if (!w_tile_empty) begin
                    // Tile ids wrap naturally at 2^ID_W.
                    r_id <= r_id + 1'b1;
                    // Preload alternates the double-buffered weight/bias
                    // register selected by propagate.
                    if (bus.cmd_preload) begin
                        r_prop <= ~r_prop;
                    end
                end
            end

            // The same counter serves both phases; it wraps to zero at the
            // end of PRELOAD so COMPUTE starts at beat 0.
            if (w_beat_fire) begin
                r_beat_cnt <= w_beat_last ? '0 : (r_beat_cnt + 1'b1);
            end

            if (r_state == S_FLUSH) begin
                r_flush_cnt <= w_flush_last ? '0 : (r_flush_cnt + 1'b1);
                if (w_flush_last) begin
                    r_done    <= 1'b1;
                    r_done_id <= r_id;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky unsupported-dataflow flag
    // ------------------------------------------------------------------------
`ifdef HF_PE_SEQ_BAD_DATAFLOW_EN
    logic r_bad_df;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bad_df <= 1'b0;
        end else if (w_accept && w_df_bad) begin
            r_bad_df <= 1'b1;
        end
    end

    assign bus.bad_dataflow = r_bad_df;
`else
    assign bus.bad_dataflow = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.cmd_ready             = w_cmd_ready;
    assign bus.out_valid             = w_out_valid;
    assign bus.out_control_dataflow  = r_dataflow;
    assign bus.out_control_propagate = r_prop;
    assign bus.out_control_shift     = r_shift;
    assign bus.out_id                = r_id;
    assign bus.out_last              = w_out_last;
    assign bus.done                  = r_done;
    assign bus.done_id               = r_done_id;

endmodule : pe_tile_sequencer
`default_nettype wire
